// File: rtl/mac_result_collector.sv
// -----------------------------------------------------------------------------
// mac_result_collector
//
// Downstream stage of the fixed-point multiply-accumulate unit. It watches the
// same new_sum pulse that opens each accumulation window and delays it by
// SUM_LAT cycles. When the delayed pulse lines up with the completed
// previous-window sum on mac_out, that sum is captured exactly once. The
// captured sum gets a per-channel bias added, is saturated to BW bits, and is
// queued in a small first-word-fall-through FIFO with a valid/ready output.
//
// Optional feature (compile-time macro RELU_EN):
//   RELU_EN defined   : a negative saturated result is clamped to 0 before the push.
//   RELU_EN undefined : the signed saturated result is pushed unchanged.
//
// Ports:
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous active-low reset
//   new_sum    in   1             window-start pulse (same signal the MAC sees)
//   mac_out    in   BW            signed accumulator output
//   bias       in   BW            signed bias, sampled on the capture cycle
//   clr_flags  in   1             synchronous clear of the sticky flags
//   out_data   out  BW            signed result at the FIFO head
//   out_valid  out  1             FIFO not empty
//   out_ready  in   1             consumer accepts out_data on valid && ready
//   overflow   out  1             sticky: a result was dropped, FIFO was full
//   frame_err  out  1             sticky: new_sum period differed from NUM_CYC
//   level      out  LOG2_DEPTH+1  current FIFO occupancy
// -----------------------------------------------------------------------------
module mac_result_collector #(
  parameter int BW         = 16,
  parameter int NUM_CYC    = 32,
  parameter int SUM_LAT    = 3,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  new_sum,
  input  logic signed [BW-1:0]  mac_out,
  input  logic signed [BW-1:0]  bias,
  input  logic                  clr_flags,
  output logic signed [BW-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic                  frame_err,
  output logic [LOG2_DEPTH:0]   level
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int CW    = $clog2(NUM_CYC + 1);

  localparam logic [CW-1:0]         CNT_MAX  = CW'(NUM_CYC);
  localparam logic [CW-1:0]         CNT_LAST = CW'(NUM_CYC - 1);
  localparam logic [LOG2_DEPTH:0]   LVL_FULL = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic signed [BW-1:0]  SAT_MAX  = {1'b0, {(BW-1){1'b1}}};
  localparam logic signed [BW-1:0]  SAT_MIN  = {1'b1, {(BW-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SUM_LAT-1:0]    dly_q, dly_d;
  logic                  primed_q, primed_d;
  logic                  seen_q, seen_d;        // at least one new_sum since reset
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_err_q, frame_err_d;
  logic [BW-1:0]         mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic                  cap;
  logic                  capture;
  logic signed [BW:0]    sum_ext;
  logic signed [BW-1:0]  wr_data;
  logic                  full;
  logic                  do_pop;
  logic                  do_push;
  logic                  drop;
  logic                  frame_set;

  assign cap = dly_q[SUM_LAT-1];

  // Delay line, priming and period tracking.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    dly_d     = dly_q << 1;
    dly_d[0]  = new_sum;
    primed_d  = primed_q | cap;
    // The first delayed pulse after reset has no previous window behind it.
    capture   = cap & primed_q;
    seen_d    = seen_q | new_sum;
    cnt_d     = cnt_q;
    if (new_sum)              cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    frame_set = new_sum & seen_q & (cnt_q != CNT_LAST);
  end

  // Bias add with saturation, then the optional clamp. This is a pure
  // combinational path from mac_out/bias straight into the FIFO write port.
  always_comb begin
    sum_ext = {mac_out[BW-1], mac_out} + {bias[BW-1], bias};
    wr_data = sum_ext[BW-1:0];
    // The two top bits disagree only when the BW-bit result has wrapped.
    if (sum_ext[BW] != sum_ext[BW-1]) begin
      wr_data = sum_ext[BW] ? SAT_MIN : SAT_MAX;
    end
`ifdef RELU_EN
    if (wr_data[BW-1]) wr_data = '0;
`endif
  end

  // FIFO control. A push into a full FIFO still succeeds when the head is
  // popped in the same cycle, because that frees the slot being written.
  always_comb begin
    full     = (level_q == LVL_FULL);
    do_pop   = out_valid & out_ready;
    do_push  = capture & (~full | do_pop);
    drop     = capture & full & ~do_pop;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // Setting a flag wins over clearing it in the same cycle.
    overflow_d  = drop      | (overflow_q  & ~clr_flags);
    frame_err_d = frame_set | (frame_err_q & ~clr_flags);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      dly_q       <= '0;
      primed_q    <= 1'b0;
      seen_q      <= 1'b0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      dly_q       <= dly_d;
      primed_q    <= primed_d;
      seen_q      <= seen_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: the storage array has no reset; out_data is forced to zero while the
  // FIFO is empty, so stale or uninitialised entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
